// File: rtl/seq_line_decoder_if.sv
// Pad-side bus of seq_line_decoder.
// The master drives the address and gate pads; the slave returns the decoded lines and status.
interface seq_line_decoder_if #(
    parameter int unsigned AW  = 3,
    parameter int unsigned GW  = 3,
    parameter int unsigned EVW = 16
);
    logic [AW-1:0]      a_i;
    logic [GW-1:0]      g_i;
    logic [(2**AW)-1:0] y_n_o;
    logic               valid_o;
    logic [AW-1:0]      idx_o;
    logic [EVW-1:0]     evt_cnt_o;

    modport master (
        output a_i,
        output g_i,
        input  y_n_o,
        input  valid_o,
        input  idx_o,
        input  evt_cnt_o
    );

    modport slave (
        input  a_i,
        input  g_i,
        output y_n_o,
        output valid_o,
        output idx_o,
        output evt_cnt_o
    );
endinterface

// File: rtl/seq_line_decoder.sv
// Registered AW-to-2^AW active-low line decoder with pad synchronisers and pulse stretch.
// Optional select-event counter is enabled by defining SEQ_DEC_EVCNT_EN.
module seq_line_decoder #(
    parameter int unsigned    AW          = 3,
    parameter int unsigned    GW          = 3,
    parameter logic [GW-1:0]  G_ACTIVE    = GW'(3'b100),
    parameter int unsigned    SYNC_STAGES = 2,
    parameter int unsigned    STRETCH     = 4,
    parameter int unsigned    EVW         = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    seq_line_decoder_if.slave bus
);

    localparam int unsigned OUTS = 2**AW;
    localparam int unsigned CW   = 8;
    localparam logic [CW-1:0] HOLD_INIT = (STRETCH == 0) ? '0 : CW'(STRETCH - 1);

    generate
        if (SYNC_STAGES < 1) begin : g_bad_sync
            $error("seq_line_decoder: SYNC_STAGES must be at least 1");
        end
        if (STRETCH > 255) begin : g_bad_stretch
            $error("seq_line_decoder: STRETCH must be in 0..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    logic [AW-1:0]   r_a_sync [SYNC_STAGES];
    logic [GW-1:0]   r_g_sync [SYNC_STAGES];
    logic [AW-1:0]   w_a_s;
    logic            w_match;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_evt_inc;

    logic [OUTS-1:0] w_y_n_nxt;
    logic [OUTS-1:0] r_y_n;
    logic            r_valid;

    // Pad synchronisers: plain flop chains, last stage feeds the FSM.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_a_sync[i] <= '0;
                r_g_sync[i] <= '0;
            end
        end else begin
            r_a_sync[0] <= bus.a_i;
            r_g_sync[0] <= bus.g_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_a_sync[i] <= r_a_sync[i-1];
                r_g_sync[i] <= r_g_sync[i-1];
            end
        end
    end

    assign w_a_s   = r_a_sync[SYNC_STAGES-1];
    assign w_match = (r_g_sync[SYNC_STAGES-1] == G_ACTIVE);

    // State, selected index and stretch counter.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; a gate drop wins over a simultaneous address change.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_evt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_match) begin
                    w_state_nxt = S_ACTIVE;
                    w_idx_nxt   = w_a_s;
                    w_evt_inc   = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_match) begin
                    if (w_a_s != r_idx) begin
                        w_idx_nxt = w_a_s;
                        w_evt_inc = 1'b1;
                    end
                end else if (STRETCH == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = HOLD_INIT;
                end
            end
            S_HOLD: begin
                if (w_match) begin
                    w_state_nxt = S_ACTIVE;
                    w_idx_nxt   = w_a_s;
                    w_evt_inc   = (w_a_s != r_idx);
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = CW'(r_cnt - 1'b1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Decoded lines come from the next index, so a switch moves the single low bit atomically.
    always_comb begin
        w_y_n_nxt = '1;
        if (w_state_nxt != S_IDLE) begin
            w_y_n_nxt[w_idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_y_n   <= '1;
            r_valid <= 1'b0;
        end else begin
            r_y_n   <= w_y_n_nxt;
            r_valid <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.y_n_o   = r_y_n;
    assign bus.valid_o = r_valid;
    assign bus.idx_o   = r_idx;

`ifdef SEQ_DEC_EVCNT_EN
    logic [EVW-1:0] r_evt;

    // Free-running select counter, wraps without saturation.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_evt <= '0;
        end else if (w_evt_inc) begin
            r_evt <= EVW'(r_evt + 1'b1);
        end
    end

    assign bus.evt_cnt_o = r_evt;
`else
    logic w_unused_evt_inc;

    assign w_unused_evt_inc = w_evt_inc;
    assign bus.evt_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_seq_line_decoder.sv
// Bench for seq_line_decoder: default instance plus a STRETCH=0 / EVW=4 instance on shared pads.
// Expected outputs are queued when pads are driven and compared when the pipeline delivers them.
module tb_seq_line_decoder;

    typedef struct {
        logic [7:0]  y;
        logic        v;
        logic [2:0]  idx;
        logic [15:0] evt;
    } out_t;

    typedef struct {
        logic [2:0] a;
        logic [2:0] g;
        out_t       e;
    } vec_t;

`ifdef SEQ_DEC_EVCNT_EN
    localparam bit EVCNT = 1'b1;
`else
    localparam bit EVCNT = 1'b0;
`endif

    localparam int NVEC = 25;

    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic [2:0] g;

    int n_checks;
    int n_errors;

    out_t sb_q0 [$];
    out_t sb_q1 [$];
    vec_t tbl [NVEC];

    // Reference model state: index 0 = default instance, 1 = STRETCH=0 / EVW=4 instance
    int       m_st   [2];
    logic [2:0] m_idx [2];
    int       m_left [2];
    int       m_evt  [2];
    int       m_stretch [2];
    int       m_evmod   [2];

    seq_line_decoder_if #(.AW(3), .GW(3), .EVW(16)) bus  ();
    seq_line_decoder_if #(.AW(3), .GW(3), .EVW(4))  bus0 ();

    assign bus.a_i  = a;
    assign bus.g_i  = g;
    assign bus0.a_i = a;
    assign bus0.g_i = g;

    seq_line_decoder #(.STRETCH(4), .EVW(16)) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus.slave)
    );

    seq_line_decoder #(.STRETCH(0), .EVW(4)) u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ev(input int n);
        return EVCNT ? 16'(n) : 16'd0;
    endfunction

    function automatic vec_t mk(input logic [2:0] va, input logic [2:0] vg, input logic [7:0] y,
                                input logic v, input logic [2:0] idx, input int evt);
        vec_t r;
        r.a     = va;
        r.g     = vg;
        r.e.y   = y;
        r.e.v   = v;
        r.e.idx = idx;
        r.e.evt = ev(evt);
        return r;
    endfunction

    function automatic out_t mdl_out(input int k);
        out_t o;
        o.y   = (m_st[k] == 0) ? 8'hFF : ~(8'h01 << m_idx[k]);
        o.v   = (m_st[k] != 0);
        o.idx = m_idx[k];
        o.evt = ev(m_evt[k]);
        return o;
    endfunction

    // States: 0 idle, 1 selected, 2 stretching; m_left counts remaining stretch cycles.
    task automatic mdl_step(input int k, input logic [2:0] ma, input logic match);
        case (m_st[k])
            0: if (match) begin
                m_st[k]  = 1;
                m_idx[k] = ma;
                m_evt[k] = (m_evt[k] + 1) % m_evmod[k];
            end
            1: if (match) begin
                if (ma != m_idx[k]) begin
                    m_idx[k] = ma;
                    m_evt[k] = (m_evt[k] + 1) % m_evmod[k];
                end
            end else if (m_stretch[k] == 0) begin
                m_st[k] = 0;
            end else begin
                m_st[k]   = 2;
                m_left[k] = m_stretch[k];
            end
            default: if (match) begin
                if (ma != m_idx[k]) m_evt[k] = (m_evt[k] + 1) % m_evmod[k];
                m_idx[k] = ma;
                m_st[k]  = 1;
            end else begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) m_st[k] = 0;
            end
        endcase
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]   = 0;
            m_idx[k]  = 3'd0;
            m_left[k] = 0;
            m_evt[k]  = 0;
        end
        sb_q0.delete();
        sb_q1.delete();
        // Synchroniser stages hold reset values, so the first edges after release stay idle
        repeat (2) begin
            sb_q0.push_back(mdl_out(0));
            sb_q1.push_back(mdl_out(1));
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_pop();
        out_t e0;
        out_t e1;
        if (sb_q0.size() == 0 || sb_q1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow at %0t: got empty queue expected an entry", $time);
            return;
        end
        e0 = sb_q0.pop_front();
        e1 = sb_q1.pop_front();
        chk("y_n",      16'(bus.y_n_o),      16'(e0.y));
        chk("valid",    16'(bus.valid_o),    16'(e0.v));
        chk("idx",      16'(bus.idx_o),      16'(e0.idx));
        chk("evt",      bus.evt_cnt_o,       e0.evt);
        chk("onehot",   16'($countones(~bus.y_n_o) <= 1), 16'd1);
        chk("y_n_s0",   16'(bus0.y_n_o),     16'(e1.y));
        chk("valid_s0", 16'(bus0.valid_o),   16'(e1.v));
        chk("idx_s0",   16'(bus0.idx_o),     16'(e1.idx));
        chk("evt_s0",   16'(bus0.evt_cnt_o), e1.evt);
        chk("onehot_s0", 16'($countones(~bus0.y_n_o) <= 1), 16'd1);
    endtask

    // Drive pads, push expectations, advance one edge and compare what the pipeline delivers.
    task automatic step(input logic [2:0] sa, input logic [2:0] sg, input bit use_tbl, input out_t te);
        a = sa;
        g = sg;
        for (int k = 0; k < 2; k++) mdl_step(k, sa, sg == 3'b100);
        if (use_tbl) sb_q0.push_back(te);
        else         sb_q0.push_back(mdl_out(0));
        sb_q1.push_back(mdl_out(1));
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_y_n",   16'(bus.y_n_o),      16'h00FF);
            chk("rst_valid", 16'(bus.valid_o),    16'd0);
            chk("rst_idx",   16'(bus.idx_o),      16'd0);
            chk("rst_evt",   bus.evt_cnt_o,       16'd0);
            chk("rst_y_n_s0", 16'(bus0.y_n_o),    16'h00FF);
            chk("rst_evt_s0", 16'(bus0.evt_cnt_o), 16'd0);
        end
        rst_n = 1'b1;
        mdl_reset();
    endtask

    initial begin
        out_t    dummy;
        logic [2:0] ra;
        logic [2:0] rg;
        int      run;

        n_checks = 0;
        n_errors = 0;
        m_stretch[0] = 4;
        m_stretch[1] = 0;
        m_evmod[0]   = 65536;
        m_evmod[1]   = 16;
        dummy = mdl_out(0);

        // Hand-derived outputs for the default instance, one row per pad cycle
        tbl[0]  = mk(3'd5, 3'b100, 8'hDF, 1'b1, 3'd5, 1);
        tbl[1]  = mk(3'd5, 3'b100, 8'hDF, 1'b1, 3'd5, 1);
        tbl[2]  = mk(3'd5, 3'b000, 8'hDF, 1'b1, 3'd5, 1);
        tbl[3]  = mk(3'd5, 3'b000, 8'hDF, 1'b1, 3'd5, 1);
        tbl[4]  = mk(3'd5, 3'b000, 8'hDF, 1'b1, 3'd5, 1);
        tbl[5]  = mk(3'd5, 3'b000, 8'hDF, 1'b1, 3'd5, 1);
        tbl[6]  = mk(3'd5, 3'b000, 8'hFF, 1'b0, 3'd5, 1);
        tbl[7]  = mk(3'd2, 3'b100, 8'hFB, 1'b1, 3'd2, 2);
        tbl[8]  = mk(3'd6, 3'b100, 8'hBF, 1'b1, 3'd6, 3);
        tbl[9]  = mk(3'd6, 3'b100, 8'hBF, 1'b1, 3'd6, 3);
        tbl[10] = mk(3'd6, 3'b000, 8'hBF, 1'b1, 3'd6, 3);
        tbl[11] = mk(3'd6, 3'b000, 8'hBF, 1'b1, 3'd6, 3);
        tbl[12] = mk(3'd6, 3'b100, 8'hBF, 1'b1, 3'd6, 3);
        tbl[13] = mk(3'd6, 3'b000, 8'hBF, 1'b1, 3'd6, 3);
        tbl[14] = mk(3'd1, 3'b100, 8'hFD, 1'b1, 3'd1, 4);
        tbl[15] = mk(3'd3, 3'b000, 8'hFD, 1'b1, 3'd1, 4);
        tbl[16] = mk(3'd3, 3'b000, 8'hFD, 1'b1, 3'd1, 4);
        tbl[17] = mk(3'd3, 3'b000, 8'hFD, 1'b1, 3'd1, 4);
        tbl[18] = mk(3'd3, 3'b000, 8'hFD, 1'b1, 3'd1, 4);
        tbl[19] = mk(3'd3, 3'b000, 8'hFF, 1'b0, 3'd1, 4);
        tbl[20] = mk(3'd3, 3'b101, 8'hFF, 1'b0, 3'd1, 4);
        tbl[21] = mk(3'd0, 3'b100, 8'hFE, 1'b1, 3'd0, 5);
        tbl[22] = mk(3'd7, 3'b100, 8'h7F, 1'b1, 3'd7, 6);
        tbl[23] = mk(3'd7, 3'b010, 8'h7F, 1'b1, 3'd7, 6);
        tbl[24] = mk(3'd7, 3'b000, 8'h7F, 1'b1, 3'd7, 6);

        // Reset with the gate already active on the pads
        a = 3'd5;
        g = 3'b100;
        do_reset(2);

        for (int i = 0; i < NVEC; i++) step(tbl[i].a, tbl[i].g, 1'b1, tbl[i].e);

        // Randomised pad activity in runs, checked against the model
        ra = 3'd0;
        rg = 3'b000;
        run = 0;
        for (int i = 0; i < 300; i++) begin
            if (run == 0) begin
                case ($urandom_range(0, 2))
                    0:       rg = 3'b100;
                    1:       rg = 3'b000;
                    default: rg = 3'($urandom_range(0, 7));
                endcase
                run = $urandom_range(1, 7);
            end
            run--;
            if ($urandom_range(0, 2) == 0) ra = 3'($urandom_range(0, 7));
            step(ra, rg, 1'b0, dummy);
        end

        // Reset while a line is selected releases it on that edge
        repeat (4) step(3'd4, 3'b100, 1'b0, dummy);
        chk("pre_rst_y_n", 16'(bus.y_n_o), 16'h00EF);
        do_reset(1);

        // 16 select events: STRETCH=0 instance re-selects each time and its 4-bit counter wraps
        for (int i = 0; i < 16; i++) begin
            step(3'd3, 3'b100, 1'b0, dummy);
            step(3'd3, 3'b000, 1'b0, dummy);
        end
        repeat (3) step(3'd3, 3'b000, 1'b0, dummy);
        chk("evt_wrap_s0", 16'(bus0.evt_cnt_o), 16'd0);
        chk("evt_reselect", bus.evt_cnt_o, ev(1));
        chk("stretch0_released", 16'(bus0.valid_o), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
